vga_draw_engine: RTL and testbench

Bus-mapped drawing sequencer that owns the frame buffer write port (A side) and turns single bus commands into pixel-write bursts. It supports plot pixel, fill rectangle and clear screen. It sits between the processor bus and the 160x120 1-bit frame buffer, next to the VGA signal generator. The processor polls the busy status or waits for a done pulse; it does not issue per-pixel bus writes.

---
 rtl/vga_draw_pkg.sv | 26 ++
 rtl/rect_scanner.sv | 56 +++++
 rtl/vga_draw_engine.sv | 133 +++++++++++++
 tb/tb_vga_draw_engine.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_draw_pkg.sv
// Shared constants, command codes and state encoding for the drawing sequencer.
// Also holds the coordinate clamp helper used for clipping.
package vga_draw_pkg;

    localparam logic [7:0] OFS_COLOUR = 8'd0;
    localparam logic [7:0] OFS_X0     = 8'd1;
    localparam logic [7:0] OFS_Y0     = 8'd2;
    localparam logic [7:0] OFS_X1     = 8'd3;
    localparam logic [7:0] OFS_Y1     = 8'd4;
    localparam logic [7:0] OFS_CMD    = 8'd5;
    localparam logic [7:0] OFS_STATUS = 8'd6;

    localparam logic [7:0] CMD_PLOT  = 8'd0;
    localparam logic [7:0] CMD_FILL  = 8'd1;
    localparam logic [7:0] CMD_CLEAR = 8'd2;

    localparam int unsigned DEFAULT_LIMIT_X = 160;
    localparam int unsigned DEFAULT_LIMIT_Y = 120;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    function automatic logic [7:0] clamp_coord(input logic [7:0] v, input logic [7:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// Nested x/y raster counter: x sweeps xs..xe inside, y sweeps ys..ye outside.
// Bounds are captured on start so the caller may change them afterwards.
module rect_scanner (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] xs,
    input  logic [7:0] xe,
    input  logic [6:0] ys,
    input  logic [6:0] ye,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       valid,
    output logic       last
);

    logic [7:0] xs_q, xe_q, x_q;
    logic [6:0] ye_q, y_q;
    logic       active_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xs_q     <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            xs_q     <= xs;
            xe_q     <= xe;
            ye_q     <= ye;
            x_q      <= xs;
            y_q      <= ys;
            active_q <= 1'b1;
        end else if (active_q) begin
            // Equality compares against the end values; counters never wrap.
            if (x_q == xe_q) begin
                x_q <= xs_q;
                if (y_q == ye_q) begin
                    active_q <= 1'b0;
                end else begin
                    y_q <= y_q + 7'd1;
                end
            end else begin
                x_q <= x_q + 8'd1;
            end
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign valid = active_q;
    assign last  = active_q && (x_q == xe_q) && (y_q == ye_q);

endmodule

// File: rtl/vga_draw_engine.sv
// Bus-mapped drawing sequencer: decodes register writes, clips the job box and
// streams one frame-buffer write per cycle with a bottom-left Y origin.
module vga_draw_engine
    import vga_draw_pkg::*;
#(
    parameter logic [7:0]  BaseAddr = 8'hB0,
    parameter int unsigned LimitX   = DEFAULT_LIMIT_X,
    parameter int unsigned LimitY   = DEFAULT_LIMIT_Y
) (
    input  logic        CLK,
    input  logic        RESET,
    inout  wire  [7:0]  BUS_DATA,
    input  logic [7:0]  BUS_ADDR,
    input  logic        BUS_WE,
    output logic [14:0] FB_ADDR,
    output logic        FB_DATA,
    output logic        FB_WE,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [7:0] MaxX   = 8'(LimitX - 1);
    localparam logic [7:0] MaxY   = 8'(LimitY - 1);
    localparam logic [6:0] MaxRow = 7'(LimitY - 1);

    state_t     state_q, state_d;
    logic [7:0] x0_q, y0_q, x1_q, y1_q;
    logic       colour_q, job_colour_q;
    logic [7:0] ofs;
    logic       reg_wr, cmd_start;
    logic [7:0] cx0, cx1, xs, xe;
    logic [6:0] cy0, cy1, ys, ye;
    logic [7:0] scan_x;
    logic [6:0] scan_y;
    logic       scan_valid, scan_last;

    // Wrapping subtraction: only addresses Base..Base+6 give offsets 0..6.
    assign ofs       = BUS_ADDR - BaseAddr;
    assign reg_wr    = BUS_WE && (state_q != RUN);
    assign cmd_start = BUS_WE && (ofs == OFS_CMD) && (state_q == IDLE) && (BUS_DATA <= CMD_CLEAR);

    assign BUS_DATA = (!BUS_WE && ofs == OFS_STATUS) ? {7'b0, BUSY} : 8'hzz;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            colour_q     <= 1'b0;
            x0_q         <= '0;
            y0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            job_colour_q <= 1'b0;
        end else begin
            if (reg_wr) begin
                case (ofs)
                    OFS_COLOUR: colour_q <= BUS_DATA[0];
                    OFS_X0:     x0_q     <= BUS_DATA;
                    OFS_Y0:     y0_q     <= BUS_DATA;
                    OFS_X1:     x1_q     <= BUS_DATA;
                    OFS_Y1:     y1_q     <= BUS_DATA;
                    default:    ;
                endcase
            end
            if (cmd_start) begin
                job_colour_q <= colour_q;
            end
        end
    end

    always_comb begin
        cx0 = clamp_coord(x0_q, MaxX);
        cx1 = clamp_coord(x1_q, MaxX);
        cy0 = 7'(clamp_coord(y0_q, MaxY));
        cy1 = 7'(clamp_coord(y1_q, MaxY));
        xs  = cx0;
        xe  = cx0;
        ys  = cy0;
        ye  = cy0;
        case (BUS_DATA)
            CMD_FILL: begin
                xs = (cx0 < cx1) ? cx0 : cx1;
                xe = (cx0 < cx1) ? cx1 : cx0;
                ys = (cy0 < cy1) ? cy0 : cy1;
                ye = (cy0 < cy1) ? cy1 : cy0;
            end
            CMD_CLEAR: begin
                xs = '0;
                xe = MaxX;
                ys = '0;
                ye = MaxRow;
            end
            default: ;
        endcase
    end

    rect_scanner u_scanner (
        .clk   (CLK),
        .rst   (RESET),
        .start (cmd_start),
        .xs    (xs),
        .xe    (xe),
        .ys    (ys),
        .ye    (ye),
        .x     (scan_x),
        .y     (scan_y),
        .valid (scan_valid),
        .last  (scan_last)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_start) state_d = RUN;
            RUN:     if (scan_last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign FB_WE   = (state_q == RUN) && scan_valid;
    assign FB_ADDR = FB_WE ? {MaxRow - scan_y, scan_x} : 15'd0;
    assign FB_DATA = job_colour_q;
    assign BUSY    = (state_q == RUN);
    assign DONE    = (state_q == FIN);

endmodule

// File: tb/tb_vga_draw_engine.sv
// Directed plus randomized bench for vga_draw_engine with a pixel-list reference model.
module tb_vga_draw_engine;

    localparam logic [7:0] BASE = 8'hB0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic        we = 1'b0;
    logic [7:0]  drv = 8'h00;
    logic        drv_en = 1'b0;
    wire  [7:0]  bus_data;
    logic [14:0] fb_addr;
    logic        fb_data, fb_we, busy, done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int busy_total = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int done_cyc[$];

    int exp_addr[$];
    int exp_colour;
    int stamp, cmd_stamp;
    int wr_base, done_base, busy_base;
    int m_colour, m_x0, m_y0, m_x1, m_y1;

    assign bus_data = drv_en ? drv : 8'hzz;

    always #5 clk = ~clk;

    vga_draw_engine #(.BaseAddr(BASE), .LimitX(160), .LimitY(120)) dut (
        .CLK      (clk),
        .RESET    (rst),
        .BUS_DATA (bus_data),
        .BUS_ADDR (addr),
        .BUS_WE   (we),
        .FB_ADDR  (fb_addr),
        .FB_DATA  (fb_data),
        .FB_WE    (fb_we),
        .BUSY     (busy),
        .DONE     (done)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fb_we) begin
            wr_addr.push_back(int'(fb_addr));
            wr_data.push_back(int'(fb_data));
            wr_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (busy) busy_total <= busy_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input int ofs, input int d);
        @(negedge clk);
        we = 1'b1; addr = BASE + 8'(ofs); drv = 8'(d); drv_en = 1'b1; stamp = cyc;
        @(negedge clk);
        we = 1'b0; drv_en = 1'b0; addr = 8'h00;
    endtask

    task automatic set_reg(input int ofs, input int d);
        bus_wr(ofs, d);
        case (ofs)
            0: m_colour = d & 1;
            1: m_x0 = d & 255;
            2: m_y0 = d & 255;
            3: m_x1 = d & 255;
            4: m_y1 = d & 255;
            default: ;
        endcase
    endtask

    task automatic read_status(input string tag, input logic exp_busy);
        @(negedge clk);
        we = 1'b0; drv_en = 1'b0; addr = BASE + 8'd6;
        #1;
        check(tag, 32'(bus_data), {31'b0, exp_busy});
        addr = 8'h00;
    endtask

    function automatic int clampv(input int v, input int lim);
        return (v > lim - 1) ? lim - 1 : v;
    endfunction

    // Reference: enumerate the clipped box row by row, bottom-left origin.
    task automatic build(input int cmd);
        int a, b, c, d, xs, xe, ys, ye;
        a = clampv(m_x0, 160); b = clampv(m_x1, 160);
        c = clampv(m_y0, 120); d = clampv(m_y1, 120);
        if (cmd == 0) begin
            xs = a; xe = a; ys = c; ye = c;
        end else if (cmd == 1) begin
            xs = (a < b) ? a : b; xe = (a < b) ? b : a;
            ys = (c < d) ? c : d; ye = (c < d) ? d : c;
        end else begin
            xs = 0; xe = 159; ys = 0; ye = 119;
        end
        exp_addr.delete();
        for (int y = ys; y <= ye; y++)
            for (int x = xs; x <= xe; x++)
                exp_addr.push_back(((119 - y) << 8) | x);
        exp_colour = m_colour;
    endtask

    task automatic start_job(input int cmd);
        wr_base = wr_addr.size(); done_base = done_cyc.size(); busy_base = busy_total;
        build(cmd);
        bus_wr(5, cmd);
        cmd_stamp = stamp;
    endtask

    task automatic finish_job(input int limit);
        int n, got, idx;
        for (int i = 0; i < limit && done_cyc.size() == done_base; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n = exp_addr.size();
        got = wr_addr.size() - wr_base;
        check("write_count", got, n);
        check("done_count", done_cyc.size() - done_base, 1);
        check("busy_cycles", busy_total - busy_base, n);
        if (got >= n) begin
            idx = 0;
            for (int i = 0; i < n; i++) begin
                if (wr_addr[wr_base + i] != exp_addr[i] || wr_data[wr_base + i] != exp_colour ||
                    wr_cyc[wr_base + i] != cmd_stamp + 1 + i) begin
                    idx = i;
                    break;
                end
            end
            check("pix_addr", wr_addr[wr_base + idx], exp_addr[idx]);
            check("pix_data", wr_data[wr_base + idx], exp_colour);
            check("pix_cycle", wr_cyc[wr_base + idx], cmd_stamp + 1 + idx);
        end
        if (done_cyc.size() > done_base) check("done_cycle", done_cyc[done_base], cmd_stamp + n + 1);
    endtask

    initial begin
        m_colour = 0; m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_fb_we", 32'(fb_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fb_addr", 32'(fb_addr), 0);
        check("rst_fb_data", 32'(fb_data), 0);
        rst = 1'b0;
        read_status("status_idle", 1'b0);

        // Single plot
        set_reg(0, 1); set_reg(1, 10); set_reg(2, 5);
        start_job(0);
        finish_job(50);
        check("plot_addr", exp_addr[0], 15'h720A);

        // Fill with swapped corners
        set_reg(1, 5); set_reg(3, 3); set_reg(2, 2); set_reg(4, 3);
        start_job(1);
        finish_job(50);

        // Fill clipped at the top-right corner
        set_reg(3, 200); set_reg(4, 250); set_reg(1, 158); set_reg(2, 158);
        start_job(1);
        finish_job(50);

        // Randomized small boxes and plots
        for (int j = 0; j < 8; j++) begin
            int bx, by;
            bx = $urandom_range(0, 170);
            by = $urandom_range(0, 125);
            set_reg(0, $urandom_range(0, 255));
            set_reg(1, bx + $urandom_range(0, 8));
            set_reg(2, by + $urandom_range(0, 8));
            set_reg(3, bx + $urandom_range(0, 8));
            set_reg(4, by + $urandom_range(0, 8));
            start_job($urandom_range(0, 1));
            finish_job(200);
        end

        // Undefined command code does nothing
        wr_base = wr_addr.size(); done_base = done_cyc.size(); busy_base = busy_total;
        bus_wr(5, 3 + $urandom_range(0, 252));
        repeat (5) @(negedge clk);
        check("badcmd_writes", wr_addr.size() - wr_base, 0);
        check("badcmd_busy", busy_total - busy_base, 0);
        check("badcmd_done", done_cyc.size() - done_base, 0);

        // Clear with writes attempted mid-burst
        set_reg(0, 0);
        start_job(2);
        read_status("status_busy", 1'b1);
        bus_wr(5, 1);
        bus_wr(1, 77);
        finish_job(20000);
        read_status("status_after", 1'b0);
        start_job(0);
        finish_job(50);

        // Reset during a clear burst
        set_reg(0, 1);
        start_job(2);
        for (int i = 0; i < 200 && (wr_addr.size() - wr_base) < 50; i++) @(negedge clk);
        check("abort_started", 32'((wr_addr.size() - wr_base) >= 50), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_fb_we", 32'(fb_we), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_fb_addr", 32'(fb_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        m_colour = 0; m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cyc.size() - done_base, 0);
        set_reg(0, 1); set_reg(1, 3); set_reg(2, 4);
        start_job(0);
        finish_job(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
